// File: rtl/jlc3_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : jlc3_uart_rx
// Description : UART receiver for the jlc3 SoC. The frame format is 8 data
//               bits, LSB first, and 1 stop bit (8N1). The rxd line is
//               synchronised internally. Received bytes go into a one-byte
//               holding register that uses a valid/ack handshake. Framing
//               and overrun errors are flagged.
// Options     : `define JLC3_UART_RX_PARITY_EN adds an even-parity bit
//               between the data and stop bits (8E1) and the parity_err_o_w
//               output.
// Ports       : clk_i_w        system clock
//               rst_i_w        asynchronous active-high reset
//               en_i_w         receiver enable; low forces IDLE
//               rxd_i_w        serial input, idle high
//               data_o_w       received byte, stable while valid_o_w=1
//               valid_o_w      holding register full
//               ack_i_w        consumer takes byte (only when valid_o_w=1)
//               frame_err_o_w  one-cycle pulse on bad stop bit
//               overrun_o_w    sticky, byte lost to a full holding register
//               parity_err_o_w one-cycle pulse on parity mismatch (option)
//               busy_o_w       receiver not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module jlc3_uart_rx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_i_w,
    input  logic       rst_i_w,
    input  logic       en_i_w,
    input  logic       rxd_i_w,
    output logic [7:0] data_o_w,
    output logic       valid_o_w,
    input  logic       ack_i_w,
    output logic       frame_err_o_w,
    output logic       overrun_o_w,
`ifdef JLC3_UART_RX_PARITY_EN
    output logic       parity_err_o_w,
`endif
    output logic       busy_o_w
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    // Half a bit, so that all later samples land in the middle of each bit
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef JLC3_UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             idx;
    logic [7:0]             shreg;
    logic                   cnt_zero;
    logic                   deliver;
`ifdef JLC3_UART_RX_PARITY_EN
    logic                   parity_bad;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser. Its reset value is high, which is the idle line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i_w or posedge rst_i_w) begin
        if (rst_i_w) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i_w};
        end
    end

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign cnt_zero = (cnt == '0);
    assign busy_o_w = (state != S_IDLE);

    // A good stop bit hands the byte to the holding register. A disabled
    // receiver never delivers.
`ifdef JLC3_UART_RX_PARITY_EN
    assign deliver = en_i_w && (state == S_STOP) && cnt_zero && rxd_s && !parity_bad;
`else
    assign deliver = en_i_w && (state == S_STOP) && cnt_zero && rxd_s;
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i_w or posedge rst_i_w) begin
        if (rst_i_w) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= 3'd0;
            shreg          <= 8'h00;
            frame_err_o_w  <= 1'b0;
`ifdef JLC3_UART_RX_PARITY_EN
            parity_bad     <= 1'b0;
            parity_err_o_w <= 1'b0;
`endif
        end else begin
            frame_err_o_w  <= 1'b0;
`ifdef JLC3_UART_RX_PARITY_EN
            parity_err_o_w <= 1'b0;
`endif
            if (!en_i_w) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!rxd_s) begin
                            state <= S_START;
                            cnt   <= HALF_LOAD;
                        end
                    end
                    S_START: begin
                        if (cnt_zero) begin
                            // A line that is high again at mid start bit
                            // was only a glitch.
                            if (!rxd_s) begin
                                state <= S_DATA;
                                cnt   <= FULL_LOAD;
                                idx   <= 3'd0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (cnt_zero) begin
                            shreg[idx] <= rxd_s;
                            cnt        <= FULL_LOAD;
                            idx        <= idx + 3'd1;
                            if (idx == 3'd7) begin
`ifdef JLC3_UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
`ifdef JLC3_UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (cnt_zero) begin
                            // Even parity: the parity bit equals the XOR of the data bits
                            parity_bad     <= (rxd_s != ^shreg);
                            parity_err_o_w <= (rxd_s != ^shreg);
                            cnt            <= FULL_LOAD;
                            state          <= S_STOP;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
`endif
                    S_STOP: begin
                        if (cnt_zero) begin
                            if (rxd_s) begin
                                state <= S_IDLE;
                            end else begin
                                frame_err_o_w <= 1'b1;
                                state         <= S_BREAK;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_BREAK: begin
                        // Wait here so that a held-low line does not look like a new start bit
                        if (rxd_s) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding register and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i_w or posedge rst_i_w) begin
        if (rst_i_w) begin
            data_o_w    <= 8'h00;
            valid_o_w   <= 1'b0;
            overrun_o_w <= 1'b0;
        end else if (deliver) begin
            if (!valid_o_w) begin
                data_o_w  <= shreg;
                valid_o_w <= 1'b1;
            end else if (ack_i_w) begin
                // The old byte is consumed in the same cycle, so nothing is lost
                data_o_w    <= shreg;
                overrun_o_w <= 1'b0;
            end else begin
                overrun_o_w <= 1'b1;
            end
        end else if (valid_o_w && ack_i_w) begin
            valid_o_w   <= 1'b0;
            overrun_o_w <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/jlc3_uart_rx.md
Name: jlc3_uart_rx

Overview:
- UART receiver for the jlc3 SoC, 8 data bits, LSB first, 1 stop bit (8N1).
- Counterpart of the SoC's UART transmit path; feeds received bytes to the CPU I/O block.
- Single clock domain; the asynchronous rxd line is synchronised internally.
- One-byte holding register with valid/ack handshake and error flags.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per bit (27 MHz / 115200). Legal range 4..65535.
- SYNC_STAGES, 2, synchroniser flops on rxd. Legal range 2..4.

Ports:
- clk_i_w  in  1  system clock.
- rst_i_w  in  1  asynchronous, active-high reset.
- en_i_w  in  1  receiver enable; low forces IDLE.
- rxd_i_w  in  1  serial input; idle high.
- data_o_w  out  8  received byte, stable while valid_o_w=1.
- valid_o_w  out  1  holding register full.
- ack_i_w  in  1  consumer takes byte; honoured only when valid_o_w=1.
- frame_err_o_w  out  1  one-cycle pulse on bad stop bit.
- overrun_o_w  out  1  sticky; byte lost because holding register was full.
- busy_o_w  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_i_w=1):
  - State IDLE; counters 0; synchroniser flops 1.
  - data_o_w=0, valid_o_w=0, frame_err_o_w=0, overrun_o_w=0, busy_o_w=0.
- Synchroniser: rxd_s is rxd_i_w delayed SYNC_STAGES cycles, reset value 1. All decisions use rxd_s.
- Bit counter: tick counter cnt, width clog2(CLKS_PER_BIT). Bit index idx, 3 bits.
- IDLE:
  - Exit when en_i_w=1 and rxd_s=0.
  - Go to START with cnt=CLKS_PER_BIT/2-1 (integer division).
- START:
  - Decrement cnt; at cnt=0 sample rxd_s.
  - rxd_s=0: go to DATA with cnt=CLKS_PER_BIT-1, idx=0.
  - rxd_s=1: false start (glitch); return to IDLE, no flags.
- DATA:
  - At cnt=0 shift rxd_s into shift register bit idx (LSB first) and reload cnt=CLKS_PER_BIT-1.
  - After idx=7, go to STOP.
- STOP, at cnt=0 sample rxd_s:
  - rxd_s=1 (good frame): deliver byte (see handshake); go to IDLE.
  - rxd_s=0: pulse frame_err_o_w for exactly 1 cycle, discard byte, go to BREAK.
- BREAK: wait for rxd_s=1, then go to IDLE. This prevents re-triggering on a held-low line.
- Delivery latency: valid_o_w rises the cycle after the stop-bit sample edge.
- Handshake and simultaneous events, evaluated at the delivery cycle:
  - valid_o_w=0: load data_o_w and set valid_o_w=1.
  - valid_o_w=1 and ack_i_w=1 in the same cycle: load the new byte; valid_o_w stays 1; no overrun.
  - valid_o_w=1 and ack_i_w=0: keep the old data and set overrun_o_w=1; the new byte is lost.
- Outside the delivery cycle, ack_i_w with valid_o_w=1 clears valid_o_w next cycle. data_o_w holds its last value.
- overrun_o_w clears on the next ack_i_w accepted while valid_o_w=1, unless that same cycle sets it again.
- ack_i_w with valid_o_w=0 is ignored.
- en_i_w deasserted mid-frame:
  - Abort to IDLE next cycle with no delivery and no flags.
  - Holding register and overrun_o_w are unaffected.
- busy_o_w is a combinational decode of state != IDLE.

Optional Feature:
- Macro JLC3_UART_RX_PARITY_EN.
- Defined:
  - Add a PARITY state between DATA and STOP, sampled at mid-bit like the data bits; frame becomes 8E1.
  - Add output parity_err_o_w (1 bit), a one-cycle pulse when the sampled parity bit differs from the XOR of the 8 data bits.
  - On parity error the byte is discarded; the STOP check still runs and may also pulse frame_err_o_w.
- Undefined: no PARITY state and no parity_err_o_w port; 8N1 exactly as above.

Test Plan:
- CLKS_PER_BIT=16. Send 0x55 as 8N1. Expect:
  - valid_o_w=1 and data_o_w=0x55 the cycle after the stop sample, ~152+SYNC_STAGES cycles after the start edge.
  - Pulse ack_i_w; valid_o_w=0 next cycle.
- Glitch: drive rxd low for 5 cycles, then high. Expect:
  - busy_o_w rises then returns low after the START sample.
  - No valid, no flags.
- Frame error: send 0xA3 with the stop bit low and the line held low for 40 cycles, then high. Expect:
  - frame_err_o_w high for exactly 1 cycle; valid_o_w stays 0.
  - FSM stays in BREAK until the line rises, then a following 0x0F is received correctly.
- Overrun: send 0x11 then 0x22 without ack. Expect:
  - data_o_w=0x11 and overrun_o_w=1 after the second frame.
  - Ack clears valid_o_w and overrun_o_w.
- Simultaneous: assert ack_i_w exactly on the delivery cycle of a second byte 0x7E. Expect data_o_w=0x7E, valid_o_w=1, overrun_o_w=0.
- Reset mid-DATA: assert rst_i_w during bit 3 of 0xC6. Expect:
  - All outputs 0 immediately (asynchronous).
  - After release, the next frame 0x3C is received cleanly.
  - With JLC3_UART_RX_PARITY_EN defined, 0x3C with a wrong parity bit gives a 1-cycle parity_err_o_w pulse and no valid.
